add_sub_round_pack: RTL

- Final stage of the FPU add/sub datapath. Accepts the normalized sign, biased exponent, 24-bit mantissa and guard/round/sticky bits, and applies round-to-nearest-even.
- The mantissa carry-out is propagated into the exponent, with overflow to infinity. The result is packed into IEEE-754 single-precision format.
- Two-stage pipeline with a valid/ready handshake on both sides; it feeds the FFT butterfly result registers.

---
 rtl/add_sub_round_pack_if.sv | 42 ++++
 rtl/add_sub_round_pack.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/add_sub_round_pack_if.sv
`default_nettype none
// ============================================================================
// Module      : add_sub_round_pack_if
// Description : Handshake and data bundle for the add/sub round-and-pack
//               stage. The slave modport is the stage's own view. The master
//               modport is the view of whoever drives operands and takes
//               results.
// Revision    : 1.0 - initial release
// ============================================================================
interface add_sub_round_pack_if #(
    parameter int SIZE_EXP = 8,
    parameter int SIZE_MAN = 23
);
    logic                         i_valid;
    logic                         o_ready;
    logic                         i_sign;
    logic [SIZE_EXP-1:0]          i_exp;
    logic [SIZE_MAN:0]            i_man;
    logic                         i_guard;
    logic                         i_round;
    logic                         i_sticky;
    logic                         i_zero;
    logic                         i_clr_flags;
    logic                         o_valid;
    logic                         i_ready;
    logic [SIZE_EXP+SIZE_MAN:0]   o_result;
    logic                         o_flag_overflow;
    logic                         o_flag_inexact;

    modport slave (
        input  i_valid, i_sign, i_exp, i_man, i_guard, i_round, i_sticky,
               i_zero, i_clr_flags, i_ready,
        output o_ready, o_valid, o_result, o_flag_overflow, o_flag_inexact
    );

    modport master (
        output i_valid, i_sign, i_exp, i_man, i_guard, i_round, i_sticky,
               i_zero, i_clr_flags, i_ready,
        input  o_ready, o_valid, o_result, o_flag_overflow, o_flag_inexact
    );
endinterface
`default_nettype wire

// File: rtl/add_sub_round_pack.sv
`default_nettype none
// ============================================================================
// Module      : add_sub_round_pack
// Description : Final add/sub stage. It applies round-to-nearest-even, carries
//               the mantissa carry-out into the exponent (saturating to
//               infinity) and packs an IEEE-754 single-precision word. The
//               block is a two-stage valid/ready pipeline.
//               Optional macro ADD_SUB_ROUND_STATUS_EN enables the sticky
//               overflow/inexact status flags. When the macro is undefined,
//               both flags are tied low.
// Revision    : 1.0 - initial release
// ============================================================================
module add_sub_round_pack #(
    parameter int SIZE_EXP = 8,
    parameter int SIZE_MAN = 23
) (
    input  wire                        i_clk,
    input  wire                        i_rst,
    add_sub_round_pack_if.slave        bus
);
    localparam logic [SIZE_EXP-1:0] c_EXP_MAX = '1;

    // ---------------- handshake ----------------
    logic r_s1_valid;
    logic r_s2_valid;
    logic w_s2_load;
    logic w_s1_adv;
    logic w_in_fire;

    assign w_s2_load   = ~r_s2_valid | bus.i_ready;
    assign w_s1_adv    = r_s1_valid & w_s2_load;
    assign bus.o_ready = ~r_s1_valid | w_s1_adv;
    assign w_in_fire   = bus.i_valid & bus.o_ready;

    // ---------------- stage 1: round decision ----------------
    logic                  w_round_up;
    logic                  w_grs;
    logic                  w_ftz;
    logic                  w_inf;
    logic                  w_inexact_s1;
    logic [SIZE_MAN+1:0]   w_sum;

    assign w_round_up = bus.i_guard & (bus.i_round | bus.i_sticky | bus.i_man[0]);
    assign w_grs      = bus.i_guard | bus.i_round | bus.i_sticky;
    assign w_sum      = {1'b0, bus.i_man} + {{(SIZE_MAN+1){1'b0}}, w_round_up};
    // Zero input or a denormal exponent flushes to a signed zero.
    assign w_ftz      = bus.i_zero | (bus.i_exp == '0);
    assign w_inf      = ~w_ftz & (bus.i_exp == c_EXP_MAX);
    // An exact zero is never inexact. A flushed denormal keeps its lost bits.
    assign w_inexact_s1 = bus.i_zero ? 1'b0 : (w_inf | w_grs);

    logic                  r_s1_sign;
    logic [SIZE_EXP-1:0]   r_s1_exp;
    logic [SIZE_MAN+1:0]   r_s1_sum;
    logic                  r_s1_inexact;
    logic                  r_s1_zero;
    logic                  r_s1_inf;

    // Stage-1 register: it loads whenever a new operand is accepted.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s1_valid   <= 1'b0;
            r_s1_sign    <= 1'b0;
            r_s1_exp     <= '0;
            r_s1_sum     <= '0;
            r_s1_inexact <= 1'b0;
            r_s1_zero    <= 1'b0;
            r_s1_inf     <= 1'b0;
        end else begin
            if (bus.o_ready) begin
                r_s1_valid <= bus.i_valid;
            end
            if (w_in_fire) begin
                r_s1_sign    <= bus.i_sign;
                r_s1_exp     <= bus.i_exp;
                r_s1_sum     <= w_sum;
                r_s1_inexact <= w_inexact_s1;
                r_s1_zero    <= w_ftz;
                r_s1_inf     <= w_inf;
            end
        end
    end

    // ---------------- stage 2: exponent adjust and pack ----------------
    logic                  w_carry;
    logic [SIZE_EXP-1:0]   w_exp_inc;
    logic [SIZE_EXP:0]     w_chain;
    logic [SIZE_MAN-1:0]   w_frac;
    logic                  w_ovf;
    logic [SIZE_EXP+SIZE_MAN:0] w_result;

    assign w_carry    = r_s1_sum[SIZE_MAN+1];
    assign w_chain[0] = w_carry;

    // Ripple increment: bit k toggles when the carry reaches it through all-ones below.
    for (genvar k = 0; k < SIZE_EXP; k++) begin : g_exp_inc
        assign w_exp_inc[k]  = r_s1_exp[k] ^ w_chain[k];
        assign w_chain[k+1]  = w_chain[k] & r_s1_exp[k];
    end

    // A carry out of the mantissa means the sum is exactly 2.0, so the fraction is zero.
    assign w_frac = w_carry ? r_s1_sum[SIZE_MAN:1] : r_s1_sum[SIZE_MAN-1:0];
    assign w_ovf  = ~r_s1_zero & (r_s1_inf | (w_exp_inc == c_EXP_MAX) | w_chain[SIZE_EXP]);

    // Result mux: a flushed zero beats infinity, and infinity beats a normal result.
    always_comb begin
        w_result = {r_s1_sign, w_exp_inc, w_frac};
        if (r_s1_zero) begin
            w_result = {r_s1_sign, {(SIZE_EXP+SIZE_MAN){1'b0}}};
        end else if (w_ovf) begin
            w_result = {r_s1_sign, c_EXP_MAX, {SIZE_MAN{1'b0}}};
        end
    end

    logic [SIZE_EXP+SIZE_MAN:0] r_s2_result;

    // Output register: it holds while the consumer stalls and loads when empty or drained.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s2_valid  <= 1'b0;
            r_s2_result <= '0;
        end else if (w_s2_load) begin
            r_s2_valid <= r_s1_valid;
            if (w_s1_adv) begin
                r_s2_result <= w_result;
            end
        end
    end

    assign bus.o_valid  = r_s2_valid;
    assign bus.o_result = r_s2_result;

`ifdef ADD_SUB_ROUND_STATUS_EN
    logic r_s2_ovf;
    logic r_s2_inexact;
    logic r_flag_ovf;
    logic r_flag_inx;
    logic w_out_fire;

    assign w_out_fire = r_s2_valid & bus.i_ready;

    // Per-result status bits travel alongside the packed word.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s2_ovf     <= 1'b0;
            r_s2_inexact <= 1'b0;
        end else if (w_s1_adv) begin
            r_s2_ovf     <= w_ovf;
            r_s2_inexact <= r_s1_inexact | w_ovf;
        end
    end

    // Sticky flags: a set on an output transfer wins over a same-cycle clear.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_flag_ovf <= 1'b0;
            r_flag_inx <= 1'b0;
        end else begin
            r_flag_ovf <= (w_out_fire & r_s2_ovf)     | (r_flag_ovf & ~bus.i_clr_flags);
            r_flag_inx <= (w_out_fire & r_s2_inexact) | (r_flag_inx & ~bus.i_clr_flags);
        end
    end

    assign bus.o_flag_overflow = r_flag_ovf;
    assign bus.o_flag_inexact  = r_flag_inx;
`else
    assign bus.o_flag_overflow = 1'b0;
    assign bus.o_flag_inexact  = 1'b0;
`endif

endmodule
`default_nettype wire
